ccd_scan_ctrl: RTL and testbench

//  Frame sequencer for the CCD line-timing block: runs calibration lines, then image lines, stepping the carriage

---
 rtl/ccd_scan_ctrl_if.sv | 34 +++
 rtl/ccd_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ccd_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_scan_ctrl_if.sv
// Host/driver bundle for the CCD frame sequencer: scan control and configuration in,
// CCD timing-block and carriage-motor controls out.
interface ccd_scan_ctrl_if;
  localparam int unsigned CNT8_W  = 8;
  localparam int unsigned CNT16_W = 16;

  logic               start;
  logic               abort;
  logic [CNT8_W-1:0]  cfg_cal_lines;
  logic [CNT16_W-1:0] cfg_lines;
  logic [CNT8_W-1:0]  cfg_steps;
  logic [CNT8_W-1:0]  cfg_div;
  logic               cfg_dir;
  logic               pix_out_valid;
  logic               ccd_en;
  logic               ccd_cal_mode;
  logic [CNT8_W-1:0]  ccd_div;
  logic               motor_step;
  logic               motor_dir;
  logic               busy;
  logic               done;
  logic               err_timeout;
  logic [CNT16_W-1:0] line_cnt;

  modport master (
    output start, abort, cfg_cal_lines, cfg_lines, cfg_steps, cfg_div, cfg_dir, pix_out_valid,
    input  ccd_en, ccd_cal_mode, ccd_div, motor_step, motor_dir, busy, done, err_timeout, line_cnt
  );

  modport slave (
    input  start, abort, cfg_cal_lines, cfg_lines, cfg_steps, cfg_div, cfg_dir, pix_out_valid,
    output ccd_en, ccd_cal_mode, ccd_div, motor_step, motor_dir, busy, done, err_timeout, line_cnt
  );
endinterface

// File: rtl/ccd_scan_ctrl.sv
// Frame sequencer: calibration lines, then image lines with motor stepping and settling between them.
// Optional SCAN_MOTOR_RETURN_EN adds a carriage return move after the last image line.
module ccd_scan_ctrl #(
  parameter int unsigned STEP_HI_CYC  = 80,
  parameter int unsigned STEP_LO_CYC  = 80,
  parameter int unsigned SETTLE_CYC   = 16000,
  parameter int unsigned LINE_TIMEOUT = 100000000
) (
  input  logic          clk_160M,
  input  logic          nrst,
  ccd_scan_ctrl_if.slave bus
);
  localparam int unsigned TO_W    = 27;
  localparam int unsigned PH_HL   = (STEP_HI_CYC > STEP_LO_CYC) ? STEP_HI_CYC : STEP_LO_CYC;
  localparam int unsigned PH_MAX  = (PH_HL > SETTLE_CYC) ? PH_HL : SETTLE_CYC;
  localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
  localparam int unsigned C8_W    = 8;
  localparam int unsigned C16_W   = 16;
`ifdef SCAN_MOTOR_RETURN_EN
  localparam int unsigned RET_W   = 24;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT_HI, S_WAIT_LO, S_STEP_HI, S_STEP_LO, S_SETTLE, S_FINISH
`ifdef SCAN_MOTOR_RETURN_EN
    , S_RETURN
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, pv_s_q, pv_p_q;
  logic [C8_W-1:0]    cal_lines_q, cal_lines_d, steps_q, steps_d, div_q, div_d;
  logic [C8_W-1:0]    cal_done_q, cal_done_d, pulse_q, pulse_d;
  logic [C16_W-1:0]   lines_q, lines_d, line_cnt_q, line_cnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               dir_q, dir_d, en_q, en_d, cal_mode_q, cal_mode_d, step_q, step_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef SCAN_MOTOR_RETURN_EN
  logic [RET_W-1:0]   ret_cnt_q, ret_cnt_d, ret_n;
  logic               ret_q, ret_d;
`endif

  logic pv_rise, pv_fall;
  assign pv_rise = pv_s_q & ~pv_p_q;
  assign pv_fall = ~pv_s_q & pv_p_q;

  // State, config latches and synchroniser for the pix-domain valid
  always_ff @(posedge clk_160M or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      pv_s_q      <= 1'b0;
      pv_p_q      <= 1'b0;
      cal_lines_q <= '0;
      steps_q     <= '0;
      div_q       <= '0;
      cal_done_q  <= '0;
      pulse_q     <= '0;
      lines_q     <= '0;
      line_cnt_q  <= '0;
      ph_q        <= '0;
      to_q        <= '0;
      dir_q       <= 1'b0;
      en_q        <= 1'b0;
      cal_mode_q  <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SCAN_MOTOR_RETURN_EN
      ret_cnt_q   <= '0;
      ret_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.pix_out_valid;
      pv_s_q      <= sync1_q;
      pv_p_q      <= pv_s_q;
      cal_lines_q <= cal_lines_d;
      steps_q     <= steps_d;
      div_q       <= div_d;
      cal_done_q  <= cal_done_d;
      pulse_q     <= pulse_d;
      lines_q     <= lines_d;
      line_cnt_q  <= line_cnt_d;
      ph_q        <= ph_d;
      to_q        <= to_d;
      dir_q       <= dir_d;
      en_q        <= en_d;
      cal_mode_q  <= cal_mode_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SCAN_MOTOR_RETURN_EN
      ret_cnt_q   <= ret_cnt_d;
      ret_q       <= ret_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cal_lines_d = cal_lines_q;
    steps_d     = steps_q;
    div_d       = div_q;
    cal_done_d  = cal_done_q;
    pulse_d     = pulse_q;
    lines_d     = lines_q;
    line_cnt_d  = line_cnt_q;
    ph_d        = ph_q;
    to_d        = to_q;
    dir_d       = dir_q;
    en_d        = en_q;
    cal_mode_d  = cal_mode_q;
    step_d      = step_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef SCAN_MOTOR_RETURN_EN
    ret_cnt_d   = ret_cnt_q;
    ret_d       = ret_q;
    ret_n       = RET_W'(lines_q - 16'd1) * RET_W'(steps_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort && !pv_s_q) begin
          cal_lines_d = bus.cfg_cal_lines;
          lines_d     = bus.cfg_lines;
          steps_d     = bus.cfg_steps;
          div_d       = bus.cfg_div;
          dir_d       = bus.cfg_dir;
          line_cnt_d  = '0;
          cal_done_d  = '0;
          err_d       = 1'b0;
`ifdef SCAN_MOTOR_RETURN_EN
          ret_d       = 1'b0;
`endif
          state_d = (bus.cfg_cal_lines == '0 && bus.cfg_lines == '0) ? S_FINISH : S_ARM;
        end
      end
      S_ARM: begin
        en_d       = 1'b1;
        cal_mode_d = (cal_done_q < cal_lines_q);
        to_d       = '0;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI, S_WAIT_LO: begin
        to_d = to_q + TO_W'(1);
        if (state_q == S_WAIT_HI && pv_rise) begin
          en_d    = 1'b0;
          state_d = S_WAIT_LO;
        end else if (state_q == S_WAIT_LO && pv_fall) begin
          if (cal_mode_q) begin
            cal_done_d = cal_done_q + 8'd1;
            state_d    = (cal_done_d == cal_lines_q && lines_q == '0) ? S_FINISH : S_ARM;
          end else begin
            line_cnt_d = line_cnt_q + 16'd1;
            ph_d       = '0;
            if (line_cnt_d == lines_q) begin
`ifdef SCAN_MOTOR_RETURN_EN
              dir_d = ~dir_q;
              if (ret_n != '0) begin
                ret_cnt_d = ret_n;
                step_d    = 1'b1;
                state_d   = S_RETURN;
              end else begin
                ret_d   = 1'b1;
                state_d = S_SETTLE;
              end
`else
              state_d = S_FINISH;
`endif
            end else if (steps_q != '0) begin
              pulse_d = '0;
              step_d  = 1'b1;
              state_d = S_STEP_HI;
            end else begin
              state_d = S_SETTLE;
            end
          end
        end else if (to_q == TO_W'(LINE_TIMEOUT - 1)) begin
          en_d       = 1'b0;
          cal_mode_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_STEP_HI: begin
        if (ph_q == PH_W'(STEP_HI_CYC - 1)) begin
          step_d  = 1'b0;
          ph_d    = '0;
          state_d = S_STEP_LO;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_STEP_LO: begin
        if (ph_q == PH_W'(STEP_LO_CYC - 1)) begin
          ph_d    = '0;
          pulse_d = pulse_q + 8'd1;
          if (pulse_d == steps_q) begin
            state_d = S_SETTLE;
          end else begin
            step_d  = 1'b1;
            state_d = S_STEP_HI;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
          ph_d = '0;
`ifdef SCAN_MOTOR_RETURN_EN
          state_d = ret_q ? S_FINISH : S_ARM;
`else
          state_d = S_ARM;
`endif
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_FINISH: begin
        done_d     = 1'b1;
        cal_mode_d = 1'b0;
        state_d    = S_IDLE;
      end
`ifdef SCAN_MOTOR_RETURN_EN
      // Return move: same pulse shape as forward steps, counted down from the total
      S_RETURN: begin
        if (step_q) begin
          if (ph_q == PH_W'(STEP_HI_CYC - 1)) begin
            step_d = 1'b0;
            ph_d   = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end else if (ph_q == PH_W'(STEP_LO_CYC - 1)) begin
          ph_d      = '0;
          ret_cnt_d = ret_cnt_q - RET_W'(1);
          if (ret_cnt_q == RET_W'(1)) begin
            ret_d   = 1'b1;
            state_d = S_SETTLE;
          end else begin
            step_d = 1'b1;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      en_d       = 1'b0;
      step_d     = 1'b0;
      cal_mode_d = 1'b0;
      done_d     = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  assign bus.ccd_en       = en_q;
  assign bus.ccd_cal_mode = cal_mode_q;
  assign bus.ccd_div      = div_q;
  assign bus.motor_step   = step_q;
  assign bus.motor_dir    = dir_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_timeout  = err_q;
  assign bus.line_cnt     = line_cnt_q;
endmodule

// File: tb/tb_ccd_scan_ctrl.sv
// Bench for ccd_scan_ctrl: event-queue model of a scan plus per-cycle pulse-shape checks,
// with a CCD timing-block model answering each ccd_en rise with a valid window.
module tb_ccd_scan_ctrl;
  localparam int STEP_HI = 3;
  localparam int STEP_LO = 2;
  localparam int SETTLE  = 10;
  localparam int LTO     = 5000;
  localparam int RISE    = 200;
  localparam int HIGH    = 2000;
  localparam int EV_EN   = 0;
  localparam int EV_STEP = 1;
  localparam int EV_DONE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccd_scan_ctrl_if bus();

  ccd_scan_ctrl #(
    .STEP_HI_CYC (STEP_HI),
    .STEP_LO_CYC (STEP_LO),
    .SETTLE_CYC  (SETTLE),
    .LINE_TIMEOUT(LTO)
  ) dut (
    .clk_160M(clk),
    .nrst    (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int   kind;
    logic flag;
  } ev_t;
  ev_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int en_rises = 0, cal_rises = 0, step_rises = 0, step_rev = 0, done_cnt = 0;
  int b_en, b_cal, b_step, b_rev, b_done;
  int en_len = 0, last_en_len = 0, st_len = 0, cyc = 0, fall_cyc = 0;
  bit gap_arm = 1'b0;
  bit mon_on = 1'b0;
  bit model_en = 1'b1;
  logic [7:0] exp_div = 8'h00;
  logic en_p = 1'b0, st_p = 1'b0, pm_en_p = 1'b0;
  int pv_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input logic f);
    ev_t e;
    e.kind = k;
    e.flag = f;
    exp_q.push_back(e);
  endtask

  // Expected event order of a complete scan, straight from the scan rules
  task automatic push_scan(input int cal, input int lines, input int steps, input logic dir);
    for (int i = 0; i < cal; i++) push_ev(EV_EN, 1'b1);
    for (int i = 0; i < lines; i++) begin
      push_ev(EV_EN, 1'b0);
      if (i < lines - 1) for (int j = 0; j < steps; j++) push_ev(EV_STEP, dir);
    end
`ifdef SCAN_MOTOR_RETURN_EN
    if (lines > 0) for (int k = 0; k < (lines - 1) * steps; k++) push_ev(EV_STEP, ~dir);
`endif
    push_ev(EV_DONE, 1'b0);
  endtask

  task automatic pop_check(input int kind, input logic flag, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event kind %0d, expected none", nm, kind);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      if (kind != EV_DONE) check({nm, "_flag"}, {31'd0, flag}, {31'd0, e.flag});
    end
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return bus.done;
      1:       return bus.busy;
      2:       return bus.motor_step;
      default: return bus.pix_out_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int max, input string nm);
    int n = 0;
    while (get_sig(which) !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, get_sig(which)}, {31'd0, val});
  endtask

  task automatic start_scan(input int cal, input int lines, input int steps, input logic [7:0] div,
                            input logic dir);
    @(negedge clk);
    bus.cfg_cal_lines = 8'(cal);
    bus.cfg_lines     = 16'(lines);
    bus.cfg_steps     = 8'(steps);
    bus.cfg_div       = div;
    bus.cfg_dir       = dir;
    exp_div           = div;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic snap();
    b_en   = en_rises;
    b_cal  = cal_rises;
    b_step = step_rises;
    b_rev  = step_rev;
    b_done = done_cnt;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  // CCD timing-block model: valid window opens RISE cycles after each ccd_en rise
  always @(negedge clk) begin
    if (bus.ccd_en && !pm_en_p && model_en) pv_cnt = 1;
    else if (pv_cnt != 0) pv_cnt = pv_cnt + 1;
    if (pv_cnt > RISE + HIGH) pv_cnt = 0;
    bus.pix_out_valid = (pv_cnt > RISE);
    pm_en_p = bus.ccd_en;
  end

  // Compare process: event order, pulse shapes, settle gap and held divisor
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (bus.ccd_en && !en_p) begin
        en_rises++;
        if (bus.ccd_cal_mode) cal_rises++;
        pop_check(EV_EN, bus.ccd_cal_mode, "ccd_en_event");
        if (gap_arm) check("settle_gap", cyc - fall_cyc, STEP_LO + SETTLE + 1);
        gap_arm = 1'b0;
        en_len = 0;
      end
      if (bus.ccd_en) en_len++;
      if (!bus.ccd_en && en_p) last_en_len = en_len;
      if (bus.motor_step && !st_p) begin
        step_rises++;
        if (!bus.motor_dir) step_rev++;
        pop_check(EV_STEP, bus.motor_dir, "step_event");
        if (gap_arm) check("step_lo_gap", cyc - fall_cyc, STEP_LO);
        gap_arm = 1'b0;
        st_len = 0;
      end
      if (bus.motor_step) st_len++;
      if (!bus.motor_step && st_p) begin
        if (bus.busy) check("step_hi_width", st_len, STEP_HI);
        gap_arm  = 1'b1;
        fall_cyc = cyc;
      end
      if (!bus.busy) gap_arm = 1'b0;
      if (bus.done) begin
        done_cnt++;
        pop_check(EV_DONE, 1'b0, "done_event");
        check("busy_at_done", {31'd0, bus.busy}, 0);
      end
      if (bus.busy) check("ccd_div_held", {24'd0, bus.ccd_div}, {24'd0, exp_div});
    end
    en_p = bus.ccd_en;
    st_p = bus.motor_step;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_cal_lines = '0;
    bus.cfg_lines = '0;
    bus.cfg_steps = '0;
    bus.cfg_div = '0;
    bus.cfg_dir = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_ccd_en", {31'd0, bus.ccd_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 0);
    check("idle_done", {31'd0, bus.done}, 0);
    check("idle_step", {31'd0, bus.motor_step}, 0);
    check("idle_dir", {31'd0, bus.motor_dir}, 0);
    check("idle_cal_mode", {31'd0, bus.ccd_cal_mode}, 0);
    check("idle_err", {31'd0, bus.err_timeout}, 0);
    check("idle_line_cnt", {16'd0, bus.line_cnt}, 0);
    check("idle_div", {24'd0, bus.ccd_div}, 0);
    mon_on = 1'b1;

    // 1) full scan: 2 cal lines, 3 image lines, 4 steps between image lines
    snap();
    push_scan(2, 3, 4, 1'b1);
    start_scan(2, 3, 4, 8'h11, 1'b1);
    wait_for(0, 1'b1, 30000, "t1_done_seen");
    @(negedge clk);
    check("t1_en_pulses", en_rises - b_en, 5);
    check("t1_cal_pulses", cal_rises - b_cal, 2);
`ifdef SCAN_MOTOR_RETURN_EN
    check("t1_step_pulses", step_rises - b_step, 16);
    check("t1_rev_pulses", step_rev - b_rev, 8);
`else
    check("t1_step_pulses", step_rises - b_step, 8);
    check("t1_rev_pulses", step_rev - b_rev, 0);
`endif
    check("t1_line_cnt", {16'd0, bus.line_cnt}, 3);
    check("t1_done_cnt", done_cnt - b_done, 1);
    check("t1_busy_after", {31'd0, bus.busy}, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2) empty scan finishes immediately
    snap();
    push_scan(0, 0, 0, 1'b0);
    start_scan(0, 0, 0, 8'h22, 1'b0);
    check("t2_busy", {31'd0, bus.busy}, 1);
    check("t2_done_early", {31'd0, bus.done}, 0);
    @(negedge clk);
    check("t2_done", {31'd0, bus.done}, 1);
    check("t2_busy_drop", {31'd0, bus.busy}, 0);
    @(negedge clk);
    check("t2_done_width", {31'd0, bus.done}, 0);
    check("t2_no_en", en_rises - b_en, 0);
    check("t2_no_step", step_rises - b_step, 0);

    // 3) line timeout when the timing block never answers
    snap();
    model_en = 1'b0;
    push_ev(EV_EN, 1'b0);
    start_scan(0, 1, 0, 8'h33, 1'b0);
    wait_for(1, 1'b0, LTO + 100, "t3_idle_seen");
    @(negedge clk);
    check("t3_en_width", last_en_len, LTO);
    check("t3_err", {31'd0, bus.err_timeout}, 1);
    check("t3_no_done", done_cnt - b_done, 0);
    check("t3_line_cnt", {16'd0, bus.line_cnt}, 0);
    model_en = 1'b1;
    push_scan(0, 1, 0, 1'b0);
    start_scan(0, 1, 0, 8'h34, 1'b0);
    check("t3_err_cleared", {31'd0, bus.err_timeout}, 0);
    wait_for(0, 1'b1, 5000, "t3_done_seen");
    @(negedge clk);
    check("t3_line_cnt2", {16'd0, bus.line_cnt}, 1);

    // 4a) abort during the first step pulse after image line 1
    snap();
    push_scan(0, 3, 4, 1'b0);
    start_scan(0, 3, 4, 8'h44, 1'b0);
    wait_for(2, 1'b1, 5000, "t4_step_seen");
    pulse_abort();
    exp_q.delete();
    check("t4_step_off", {31'd0, bus.motor_step}, 0);
    check("t4_busy_off", {31'd0, bus.busy}, 0);
    check("t4_en_off", {31'd0, bus.ccd_en}, 0);
    repeat (50) @(negedge clk);
    check("t4_step_count", step_rises - b_step, 1);
    check("t4_no_done", done_cnt - b_done, 0);

    // 4b) abort mid-line; start while valid drains is dropped, start after it is accepted
    snap();
    push_scan(0, 1, 0, 1'b0);
    start_scan(0, 1, 0, 8'h45, 1'b0);
    wait_for(3, 1'b1, 1000, "t4b_valid_high");
    repeat (5) @(negedge clk);
    pulse_abort();
    exp_q.delete();
    start_scan(0, 1, 0, 8'h46, 1'b0);
    check("t4b_start_dropped", {31'd0, bus.busy}, 0);
    wait_for(3, 1'b0, 3000, "t4b_valid_low");
    repeat (3) @(negedge clk);
    push_scan(0, 1, 0, 1'b0);
    start_scan(0, 1, 0, 8'h47, 1'b0);
    check("t4b_start_taken", {31'd0, bus.busy}, 1);
    wait_for(0, 1'b1, 5000, "t4b_done_seen");
    @(negedge clk);
    check("t4b_en_pulses", en_rises - b_en, 2);
    check("t4b_done_cnt", done_cnt - b_done, 1);

    // 5) start+abort together in IDLE; config changes mid-scan are ignored
    snap();
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t5_abort_wins", {31'd0, bus.busy}, 0);
    push_scan(1, 1, 0, 1'b0);
    start_scan(1, 1, 0, 8'h5A, 1'b0);
    @(negedge clk);
    bus.cfg_div = 8'hC3;
    bus.cfg_lines = 16'd9;
    bus.cfg_cal_lines = 8'd0;
    wait_for(0, 1'b1, 8000, "t5_done_seen");
    @(negedge clk);
    check("t5_div_latched", {24'd0, bus.ccd_div}, 32'h5A);
    check("t5_line_cnt", {16'd0, bus.line_cnt}, 1);
    check("t5_en_pulses", en_rises - b_en, 2);
    check("t5_cal_pulses", cal_rises - b_cal, 1);

`ifdef SCAN_MOTOR_RETURN_EN
    // 6) forward steps then return move in the opposite direction
    snap();
    push_scan(0, 3, 4, 1'b1);
    start_scan(0, 3, 4, 8'h66, 1'b1);
    wait_for(0, 1'b1, 15000, "t6_done_seen");
    @(negedge clk);
    check("t6_step_pulses", step_rises - b_step, 16);
    check("t6_rev_pulses", step_rev - b_rev, 8);
    check("t6_line_cnt", {16'd0, bus.line_cnt}, 3);
    check("t6_dir_after", {31'd0, bus.motor_dir}, 0);
    check("t6_done_cnt", done_cnt - b_done, 1);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
